// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: opcode/memory handshake in, datapath controls out.
// The master modport is the control unit, the slave modport is the datapath side.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int STATE_W  = 4
);
    // From the instruction register and the shared memory
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;

    // Datapath controls
    logic                pc_write;
    logic                branch;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic [1:0]          pc_src;

    // Status and debug
    logic                illegal_op;
    logic                mem_timeout;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal_op, mem_timeout, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects per state and bounds every memory wait with a timeout.
// Optional feature macro: MCU_JUMP_EN (adds the j instruction and the JUMP state;
// without it opcode 000010 is reported as illegal).
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int STATE_W  = 4,
    parameter int WAIT_MAX = 15
) (
    input logic                      clk,
    input logic                      rst_n,
    multicycle_control_unit_if.master bus
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
`ifdef MCU_JUMP_EN
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
`endif

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
`ifdef MCU_JUMP_EN
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_EXEC   = STATE_W'(6),
        S_ALUWB  = STATE_W'(7),
        S_BRANCH = STATE_W'(8),
        S_ADDIEX = STATE_W'(9),
        S_ADDIWB = STATE_W'(10),
        S_JUMP   = STATE_W'(11)
    } state_e;

    typedef struct packed {
        logic               pc_write;
        logic               branch;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_src;
    } ctrl_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               illegal_op_q, illegal_op_d;
    logic               mem_timeout_q, mem_timeout_d;
    ctrl_t              ctrl;
    ctrl_t              ctrl_gated;
    logic               in_mem_state;
    logic               wait_expired;

    // Memory-handshake states are the only ones that may stall or time out
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR);
    assign wait_expired = (wait_q == CNT_W'(WAIT_MAX));

    // State register, wait counter and registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            wait_q        <= '0;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            wait_q        <= wait_d;
            illegal_op_q  <= illegal_op_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state logic and Moore decode of the datapath controls
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a value held (no latch is inferred).
        state_d       = state_q;
        wait_d        = '0;
        illegal_op_d  = 1'b0;
        mem_timeout_d = 1'b0;
        ctrl          = '0;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                // PC+4 and IR load only on the cycle the instruction arrives
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precompute: PC + (imm << 2)
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEX;
`ifdef MCU_JUMP_EN
                    OP_J:          state_d = S_JUMP;
`endif
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                // IR holds the opcode, so it still selects load vs store here
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.branch    = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                state_d        = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
                state_d        = S_FETCH;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
                state_d       = S_FETCH;
            end
`endif
            default: begin
                // Unused encodings recover to FETCH with all controls idle
                state_d = S_FETCH;
            end
        endcase

        // Stall accounting: a state change leaves wait_d at its cleared default
        if (in_mem_state && !bus.mem_ready) begin
            if (wait_expired) begin
                state_d       = S_FETCH;
                mem_timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + CNT_W'(1);
            end
        end
    end

    // Controls are forced idle for as long as reset is held, not just after the edge
    assign ctrl_gated = rst_n ? ctrl : '0;

    assign bus.pc_write    = ctrl_gated.pc_write;
    assign bus.branch      = ctrl_gated.branch;
    assign bus.i_or_d      = ctrl_gated.i_or_d;
    assign bus.mem_read    = ctrl_gated.mem_read;
    assign bus.mem_write   = ctrl_gated.mem_write;
    assign bus.ir_write    = ctrl_gated.ir_write;
    assign bus.mem_to_reg  = ctrl_gated.mem_to_reg;
    assign bus.reg_dst     = ctrl_gated.reg_dst;
    assign bus.reg_write   = ctrl_gated.reg_write;
    assign bus.alu_src_a   = ctrl_gated.alu_src_a;
    assign bus.alu_src_b   = ctrl_gated.alu_src_b;
    assign bus.alu_op      = ctrl_gated.alu_op;
    assign bus.pc_src      = ctrl_gated.pc_src;
    assign bus.illegal_op  = illegal_op_q;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.state       = state_q;

endmodule
